bsg_cache_to_dram_ctrl_rx_credit: RTL and testbench
===================================================

Name: bsg_cache_to_dram_ctrl_rx_credit

Overview:
Read-return stage of the cache-to-DRAM-controller bridge; the counterpart of the write-data (tx) path.
- Accepts a read-request tag identifying the requesting cache.
- Buffers the DRAM controller's unthrottled read data (valid only, no ready).
- Steers each word to the owning cache's DMA data port with a valid/ready handshake.
- Credit accounting refuses new requests unless buffer space for a whole block is reserved, so read data can never overflow.

Parameters:
num_cache_p, 2, number of caches sharing the DRAM controller; tag width lg_num_cache_lp = max(1, clog2(num_cache_p)).
data_width_p, 32, width of one DRAM read word and one DMA word.
block_size_in_words_p, 4, words returned per request.
data_fifo_els_p, 8, read-data buffer depth; must be >= block_size_in_words_p.
tag_fifo_els_p, 8, outstanding-request tag buffer depth.

Ports:
clk_i  in  1  clock; all state on rising edge.
reset_n_i  in  1  asynchronous, active-low reset.
v_i  in  1  read request valid.
tag_i  in  lg_num_cache_lp  requesting cache index.
ready_o  out  1  request accepted when v_i & ready_o.
app_rd_data_valid_i  in  1  DRAM read word valid; cannot be stalled.
app_rd_data_i  in  data_width_p  DRAM read word.
dma_data_o  out  data_width_p  head read word, broadcast to all caches.
dma_data_v_o  out  num_cache_p  one-hot valid for the owning cache.
dma_data_ready_i  in  num_cache_p  per-cache ready.
credits_o  out  clog2(data_fifo_els_p+1)  free reserved-word credits (debug).
overflow_o  out  1  sticky error: write attempted while data FIFO full.

Behaviour:
Reset (reset_n_i low, async assert, sync deassert):
- Both FIFOs empty; word counter = 0.
- credits = data_fifo_els_p; overflow_o = 0.
- Resulting outputs: dma_data_v_o = 0, ready_o = 1.
- Reset mid-block discards all buffered data and tags.

Request side:
- ready_o = ~tag_fifo_full & (credits >= block_size_in_words_p); combinational from registered state only.
- Accept: push tag_i; credits -= block_size_in_words_p.

Data side:
- app_rd_data_valid_i pushes app_rd_data_i into the data FIFO every valid cycle.
- If valid while the FIFO is full: drop the word and set overflow_o until reset. This cannot occur when the credit rule holds.

Delivery:
- Let head_v = ~data_empty & ~tag_empty, head_tag = tag FIFO head.
- dma_data_v_o[k] = head_v & (head_tag == k); dma_data_o = data FIFO head.
- Valid never depends on ready.
- deliver = |(dma_data_v_o & dma_data_ready_i): pop data FIFO; credits += 1.
- Word counter counts deliveries 0..block_size_in_words_p-1. On the delivery at count block-1: counter -> 0 and pop tag FIFO in the same cycle.
- Data arriving before its tag is held until the tag is present.

Simultaneous events:
- Accept and deliver in the same cycle: credits += 1 - block_size_in_words_p.
- Push and pop of the data FIFO in the same cycle are both legal, including when full (pop frees the slot, so no overflow) and when empty (word appears next cycle; no bypass).
- Credits never exceed data_fifo_els_p and never go negative.

Latency:
- Read word on app_rd_data_valid_i at cycle t appears on dma_data_o at t+1 at the earliest.
- Tag accepted at t enables delivery at t+1 at the earliest.

Wrap-around: FIFO pointers wrap modulo depth; full/empty are distinguished by last-operation tracking.

Test Plan:
- Single block: defaults, tag_i=1 accepted; 4 words 0xA0..0xA3 on consecutive cycles; dma_data_ready_i=2'b11 -> dma_data_v_o=2'b10 from cycle after first word; words delivered in order; tag popped on 4th; credits 8->4->8.
- Credit limit: two requests accepted, no data returned -> ready_o=0, credits_o=0. After 1 word delivered, still ready_o=0. After 4th word delivered, ready_o=1.
- Interleaved caches: tags 0,1 queued; 8 words returned back-to-back with dma_data_ready_i[0] stalled for 3 cycles -> no words lost; v_o[0] for words 0-3, then v_o[1] for 4-7; overflow_o stays 0.
- Simultaneous accept+deliver: credits=4, request accepted in same cycle as delivery -> credits_o=1 next cycle.
- Forced overflow: 9 words driven with no tag/credit reservation and ready low -> 9th dropped, overflow_o=1 and sticky; first 8 words intact.
- Async reset mid-block: reset_n_i low after 2 of 4 words delivered, asynchronously, between edges -> dma_data_v_o=0, credits_o=8, overflow_o=0 immediately; after release, a fresh request completes normally.

Source files
------------

// File: rtl/bsg_cache_to_dram_ctrl_rx_credit_if.sv
// Read-return bundle between the DRAM controller, the request source and the caches.
// Handshakes: a transfer happens on a cycle where valid & ready are both high at the rising edge;
// valid never waits for ready, and app_rd_data_valid_i has no ready at all.
`timescale 1ns/1ps
interface bsg_cache_to_dram_ctrl_rx_credit_if #(
    parameter int num_cache_p  = 2,
    parameter int data_width_p = 32
);
    localparam int lg_num_cache_lp = (num_cache_p > 1) ? $clog2(num_cache_p) : 1;

    logic                       v_i;
    logic [lg_num_cache_lp-1:0] tag_i;
    logic                       ready_o;
    logic                       app_rd_data_valid_i;
    logic [data_width_p-1:0]    app_rd_data_i;
    logic [data_width_p-1:0]    dma_data_o;
    logic [num_cache_p-1:0]     dma_data_v_o;
    logic [num_cache_p-1:0]     dma_data_ready_i;

    modport slave (
        input  v_i, tag_i, app_rd_data_valid_i, app_rd_data_i, dma_data_ready_i,
        output ready_o, dma_data_o, dma_data_v_o
    );

    modport master (
        output v_i, tag_i, app_rd_data_valid_i, app_rd_data_i, dma_data_ready_i,
        input  ready_o, dma_data_o, dma_data_v_o
    );
endinterface

// File: rtl/bsg_cache_to_dram_ctrl_rx_credit.sv
// Read-return path: buffers unthrottled DRAM read data and steers each block to the cache
// whose tag heads the request queue; credits reserve a whole block before a request is taken.
`timescale 1ns/1ps
module bsg_cache_to_dram_ctrl_rx_credit_fifo #(
    parameter int width_p = 32,
    parameter int els_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic                last_push_q, last_push_d;
    logic                ptr_eq, do_push, do_pop;

    // Equal pointers are disambiguated by whether the last change was a push.
    assign ptr_eq  = (wptr_q == rptr_q);
    assign full_o  = ptr_eq & last_push_q;
    assign empty_o = ptr_eq & ~last_push_q;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rptr_q];

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        last_push_d = last_push_q;
        if (do_push) wptr_d = next_ptr(wptr_q);
        if (do_pop)  rptr_d = next_ptr(rptr_q);
        if (do_push & ~do_pop) last_push_d = 1'b1;
        if (do_pop & ~do_push) last_push_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            last_push_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            last_push_q <= last_push_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end
endmodule

module bsg_cache_to_dram_ctrl_rx_credit #(
    parameter int num_cache_p           = 2,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 4,
    parameter int data_fifo_els_p       = 8,
    parameter int tag_fifo_els_p        = 8,
    localparam int lg_num_cache_lp      = (num_cache_p > 1) ? $clog2(num_cache_p) : 1,
    localparam int credit_w_lp          = $clog2(data_fifo_els_p + 1)
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    bsg_cache_to_dram_ctrl_rx_credit_if.slave io,
    output logic [credit_w_lp-1:0]            credits_o,
    output logic                              overflow_o
);
    localparam int cnt_w_lp = (block_size_in_words_p > 1) ? $clog2(block_size_in_words_p) : 1;

    logic                       data_full, data_empty, tag_full, tag_empty;
    logic [lg_num_cache_lp-1:0] head_tag;
    logic                       head_v, accept, deliver, last_word, tag_pop;
    logic [credit_w_lp-1:0]     credits_q, credits_d;
    logic [cnt_w_lp-1:0]        cnt_q, cnt_d;
    logic                       overflow_q, overflow_d;

    bsg_cache_to_dram_ctrl_rx_credit_fifo #(
        .width_p(data_width_p),
        .els_p  (data_fifo_els_p)
    ) data_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .push_i   (io.app_rd_data_valid_i),
        .pop_i    (deliver),
        .data_i   (io.app_rd_data_i),
        .data_o   (io.dma_data_o),
        .full_o   (data_full),
        .empty_o  (data_empty)
    );

    bsg_cache_to_dram_ctrl_rx_credit_fifo #(
        .width_p(lg_num_cache_lp),
        .els_p  (tag_fifo_els_p)
    ) tag_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .push_i   (accept),
        .pop_i    (tag_pop),
        .data_i   (io.tag_i),
        .data_o   (head_tag),
        .full_o   (tag_full),
        .empty_o  (tag_empty)
    );

    // ready_o looks only at registered state so it cannot loop back through v_i.
    assign io.ready_o = ~tag_full & (credits_q >= credit_w_lp'(block_size_in_words_p));
    assign accept     = io.v_i & io.ready_o;
    assign head_v     = ~data_empty & ~tag_empty;
    assign deliver    = |(io.dma_data_v_o & io.dma_data_ready_i);
    assign last_word  = (cnt_q == cnt_w_lp'(block_size_in_words_p - 1));
    assign tag_pop    = deliver & last_word;
    assign credits_o  = credits_q;
    assign overflow_o = overflow_q;

    always_comb begin
        io.dma_data_v_o = '0;
        for (int k = 0; k < num_cache_p; k++) begin
            io.dma_data_v_o[k] = head_v & (head_tag == lg_num_cache_lp'(k));
        end
    end

    always_comb begin
        credits_d  = credits_q + credit_w_lp'(deliver)
                   - (accept ? credit_w_lp'(block_size_in_words_p) : '0);
        cnt_d      = cnt_q;
        if (deliver) cnt_d = last_word ? '0 : cnt_q + 1'b1;
        // A same-cycle delivery frees the slot, so a full-FIFO write is then not a drop.
        overflow_d = overflow_q | (io.app_rd_data_valid_i & data_full & ~deliver);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credits_q  <= credit_w_lp'(data_fifo_els_p);
            cnt_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            credits_q  <= credits_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_bsg_cache_to_dram_ctrl_rx_credit.sv
// Bench for the read-return credit stage: a cycle table for one block, then hand-written
// sequences; every delivered word is matched against an expected queue of {owner, data}.
`timescale 1ns/1ps
module tb_bsg_cache_to_dram_ctrl_rx_credit;
    localparam int N   = 2;
    localparam int DW  = 32;
    localparam int TW  = 1;
    localparam int BLK = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [CW-1:0] credits;
    logic          overflow;
    int            checks = 0;
    int            errors = 0;

    logic [N+DW-1:0] exp_q[$];
    logic [TW-1:0]   pend_tags[$];
    int              wcnt = 0;

    typedef struct packed {
        logic          v;
        logic [TW-1:0] tag;
        logic          app_v;
        logic [DW-1:0] app_d;
        logic [N-1:0]  rdy;
        logic          e_ready;
        logic [N-1:0]  e_dv;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_cred;
    } vec_t;
    vec_t vecs [7];

    bsg_cache_to_dram_ctrl_rx_credit_if #(.num_cache_p(N), .data_width_p(DW)) intf ();

    bsg_cache_to_dram_ctrl_rx_credit #(
        .num_cache_p(N), .data_width_p(DW), .block_size_in_words_p(BLK),
        .data_fifo_els_p(8), .tag_fifo_els_p(8)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .io        (intf),
        .credits_o (credits),
        .overflow_o(overflow)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard: compare every word accepted by a cache against the queue head
    task automatic sb_check();
        logic [N-1:0]    fire;
        logic [N+DW-1:0] e;
        fire = intf.dma_data_v_o & intf.dma_data_ready_i;
        if (reset_n && fire != '0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_spurious: got v=%0h data=%0h expected nothing", intf.dma_data_v_o, intf.dma_data_o);
            end else begin
                e = exp_q.pop_front();
                if ({intf.dma_data_v_o, intf.dma_data_o} !== e) begin
                    errors++;
                    $display("FAIL sb_word: got v=%0h data=%0h expected v=%0h data=%0h",
                             intf.dma_data_v_o, intf.dma_data_o, e[N+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        sb_check();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        to_neg();
        to_pos();
    endtask

    // driver: present one read word and record where it must end up
    task automatic drive_word(input logic [DW-1:0] d);
        logic [N-1:0]  oh;
        logic [TW-1:0] owner;
        intf.app_rd_data_valid_i = 1'b1;
        intf.app_rd_data_i       = d;
        owner = (pend_tags.size() > 0) ? pend_tags[0] : '0;
        oh = '0;
        oh[owner] = 1'b1;
        exp_q.push_back({oh, d});
        wcnt++;
        if (wcnt == BLK) begin
            if (pend_tags.size() > 0) void'(pend_tags.pop_front());
            wcnt = 0;
        end
    endtask

    task automatic request(input logic [TW-1:0] t);
        intf.v_i   = 1'b1;
        intf.tag_i = t;
        pend_tags.push_back(t);
        to_neg();
        check("req_ready", intf.ready_o, 1);
        to_pos();
        intf.v_i = 1'b0;
    endtask

    task automatic push_block(input logic [DW-1:0] base);
        for (int i = 0; i < BLK; i++) begin
            drive_word(base + DW'(i));
            step();
        end
        intf.app_rd_data_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        intf.dma_data_ready_i = '1;
        while (exp_q.size() > 0 && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL %s: got %0d words pending expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        intf.v_i = 1'b0;
        intf.tag_i = '0;
        intf.app_rd_data_valid_i = 1'b0;
        intf.app_rd_data_i = '0;
        intf.dma_data_ready_i = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", intf.ready_o, 1);
        check("rst_dv", intf.dma_data_v_o, 0);
        check("rst_credits", credits, 8);
        check("rst_overflow", overflow, 0);
        reset_n = 1'b1;
        to_pos();

        // single block, one row per cycle; expected outputs are those visible before the row's edge
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  2'b11, 1'b1, 2'b00, 32'h0,  4'd8};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 32'hA0, 2'b11, 1'b1, 2'b00, 32'h0,  4'd4};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 32'hA1, 2'b11, 1'b1, 2'b10, 32'hA0, 4'd4};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 32'hA2, 2'b11, 1'b1, 2'b10, 32'hA1, 4'd5};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 32'hA3, 2'b11, 1'b1, 2'b10, 32'hA2, 4'd6};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 32'h0,  2'b11, 1'b1, 2'b10, 32'hA3, 4'd7};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,  2'b11, 1'b1, 2'b00, 32'h0,  4'd8};
        for (int i = 0; i < 7; i++) begin
            intf.v_i = vecs[i].v;
            intf.tag_i = vecs[i].tag;
            intf.app_rd_data_valid_i = vecs[i].app_v;
            intf.app_rd_data_i = vecs[i].app_d;
            intf.dma_data_ready_i = vecs[i].rdy;
            if (vecs[i].v) pend_tags.push_back(vecs[i].tag);
            if (vecs[i].app_v) drive_word(vecs[i].app_d);
            to_neg();
            check($sformatf("vec%0d_ready", i), intf.ready_o, vecs[i].e_ready);
            check($sformatf("vec%0d_dv", i), intf.dma_data_v_o, vecs[i].e_dv);
            check($sformatf("vec%0d_credits", i), credits, vecs[i].e_cred);
            if (vecs[i].e_dv != '0) check($sformatf("vec%0d_data", i), intf.dma_data_o, vecs[i].e_data);
            to_pos();
        end
        intf.v_i = 1'b0;
        intf.app_rd_data_valid_i = 1'b0;

        // credit limit
        intf.dma_data_ready_i = 2'b00;
        request(0);
        request(1);
        to_neg();
        check("lim_ready0", intf.ready_o, 0);
        check("lim_credits0", credits, 0);
        to_pos();
        push_block(32'hB0);
        intf.dma_data_ready_i = 2'b01;
        step();
        intf.dma_data_ready_i = 2'b00;
        to_neg();
        check("lim_ready1", intf.ready_o, 0);
        check("lim_credits1", credits, 1);
        to_pos();
        intf.dma_data_ready_i = 2'b01;
        repeat (3) step();
        intf.dma_data_ready_i = 2'b00;
        to_neg();
        check("lim_ready4", intf.ready_o, 1);
        check("lim_credits4", credits, 4);
        to_pos();
        push_block(32'hC0);
        wait_drain("lim_drain");
        to_neg();
        check("lim_credits_end", credits, 8);
        to_pos();

        // interleaved caches with cache 0 stalled for three cycles
        intf.dma_data_ready_i = 2'b00;
        request(0);
        request(1);
        for (int i = 0; i < 8; i++) begin
            drive_word(32'hD0 + DW'(i));
            intf.dma_data_ready_i = (i < 3) ? 2'b10 : 2'b11;
            step();
        end
        intf.app_rd_data_valid_i = 1'b0;
        wait_drain("il_drain");
        to_neg();
        check("il_overflow", overflow, 0);
        check("il_credits", credits, 8);
        to_pos();

        // accept and deliver in the same cycle
        intf.dma_data_ready_i = 2'b00;
        request(0);
        push_block(32'hE0);
        intf.v_i = 1'b1;
        intf.tag_i = 1'b1;
        pend_tags.push_back(1'b1);
        intf.dma_data_ready_i = 2'b01;
        to_neg();
        check("sim_ready", intf.ready_o, 1);
        to_pos();
        intf.v_i = 1'b0;
        intf.dma_data_ready_i = 2'b00;
        to_neg();
        check("sim_credits", credits, 1);
        to_pos();
        push_block(32'hF0);
        wait_drain("sim_drain");

        // forced overflow: nine words with nothing reserved
        intf.dma_data_ready_i = 2'b00;
        for (int i = 0; i < 9; i++) begin
            intf.app_rd_data_valid_i = 1'b1;
            intf.app_rd_data_i = 32'h100 + DW'(i);
            step();
        end
        intf.app_rd_data_valid_i = 1'b0;
        to_neg();
        check("ovf_set", overflow, 1);
        to_pos();
        repeat (3) step();
        to_neg();
        check("ovf_sticky", overflow, 1);
        to_pos();
        request(0);
        request(1);
        pend_tags.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back({(i < 4) ? 2'b01 : 2'b10, 32'h100 + DW'(i)});
        wait_drain("ovf_drain");
        to_neg();
        check("ovf_credits", credits, 8);
        check("ovf_still", overflow, 1);
        to_pos();

        // asynchronous reset mid-block
        intf.dma_data_ready_i = 2'b00;
        request(1);
        push_block(32'h200);
        intf.dma_data_ready_i = 2'b10;
        repeat (2) step();
        intf.dma_data_ready_i = 2'b00;
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_dv", intf.dma_data_v_o, 0);
        check("arst_credits", credits, 8);
        check("arst_overflow", overflow, 0);
        check("arst_ready", intf.ready_o, 1);
        exp_q.delete();
        pend_tags.delete();
        wcnt = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        to_pos();
        request(0);
        push_block(32'h300);
        wait_drain("arst_drain");
        to_neg();
        check("arst_credits_end", credits, 8);
        to_pos();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
